mem_arbiter: RTL and testbench

Two-requester arbiter sharing one single-port synchronous word RAM between the instruction fetch stage (port 0) and the instruction decoder's load/store path (port 1). Each requester uses the en/we/addr/di in, do/do_ack out handshake that the decoder already drives. The arbiter serialises requests with round-robin priority and issues exactly one RAM access at a time. It returns read data and a one-cycle acknowledge to the owning port.

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_arbiter: round-robin arbiter sharing one single-port word RAM       |
// | between two en/we/addr/di requesters.           Rev 1.0                 |
// +------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_en,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_di,
  output logic [DATA_WIDTH-1:0] p0_do,
  output logic                  p0_do_ack,
  input  logic                  p1_en,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_di,
  output logic [DATA_WIDTH-1:0] p1_do,
  output logic                  p1_do_ack,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do,
  output logic                  busy
);

  localparam logic [2:0] C_LAT_LOAD = 3'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_last_grant;
  logic       r_grant;
  logic [2:0] r_cnt;
  logic       w_pick;

  // On a tie the port that was not served last wins; otherwise the lone requester.
  assign w_pick = (p0_en && p1_en) ? ~r_last_grant : p1_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_cnt        <= 3'd0;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_di       <= '0;
      p0_do        <= '0;
      p1_do        <= '0;
      p0_do_ack    <= 1'b0;
      p1_do_ack    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (p0_en || p1_en) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            ram_en       <= 1'b1;
            ram_we       <= w_pick ? p1_we   : p0_we;
            ram_addr     <= w_pick ? p1_addr : p0_addr;
            ram_di       <= w_pick ? p1_di   : p0_di;
            busy         <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // ram_we still carries the latched direction of this access
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          if (ram_we) begin
            if (r_grant) p1_do_ack <= 1'b1;
            else         p0_do_ack <= 1'b1;
            r_state <= S_ACK;
          end else begin
            r_cnt   <= C_LAT_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            if (r_grant) begin
              p1_do     <= ram_do;
              p1_do_ack <= 1'b1;
            end else begin
              p0_do     <= ram_do;
              p0_do_ack <= 1'b1;
            end
            r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_ACK: begin
          p0_do_ack <= 1'b0;
          p1_do_ack <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_arbiter: scoreboard bench for mem_arbiter (latency 1 and 3).    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          p0_en = 0, p0_we = 0, p1_en = 0, p1_we = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_di = '0, p1_di = '0;
  logic [DW-1:0] p0_do, p1_do;
  logic          p0_do_ack, p1_do_ack;
  logic          ram_en, ram_we, busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di, ram_do;

  logic          b_en = 0, b_we = 0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_di = '0;
  logic [DW-1:0] b_p0_do, b_p1_do;
  logic          b_p0_ack, b_p1_ack, b_ram_en, b_ram_we, b_busy;
  logic [AW-1:0] b_ram_addr;
  logic [DW-1:0] b_ram_di, b_ram_do;
  logic          b_zero = 1'b0;
  logic [AW-1:0] b_zaddr = '0;
  logic [DW-1:0] b_zdata = '0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .p0_en(p0_en), .p0_we(p0_we), .p0_addr(p0_addr), .p0_di(p0_di),
    .p0_do(p0_do), .p0_do_ack(p0_do_ack),
    .p1_en(p1_en), .p1_we(p1_we), .p1_addr(p1_addr), .p1_di(p1_di),
    .p1_do(p1_do), .p1_do_ack(p1_do_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_do(ram_do), .busy(busy)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .p0_en(b_en), .p0_we(b_we), .p0_addr(b_addr), .p0_di(b_di),
    .p0_do(b_p0_do), .p0_do_ack(b_p0_ack),
    .p1_en(b_zero), .p1_we(b_zero), .p1_addr(b_zaddr), .p1_di(b_zdata),
    .p1_do(b_p1_do), .p1_do_ack(b_p1_ack),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_di(b_ram_di),
    .ram_do(b_ram_do), .busy(b_busy)
  );

  // RAM models: read data is valid only for one cycle, otherwise a filler pattern.
  logic [DW-1:0] mem1 [1024];
  logic          rd_v1 = 1'b0;
  logic [DW-1:0] rd_d1 = '0;
  always @(posedge clk) begin
    if (ram_en && ram_we) mem1[ram_addr] <= ram_di;
    rd_v1 <= ram_en && !ram_we;
    rd_d1 <= mem1[ram_addr];
  end
  assign ram_do = rd_v1 ? rd_d1 : 32'h0BAD0BAD;

  logic [DW-1:0] mem3 [1024];
  logic [2:0]    v3 = 3'b000;
  logic [DW-1:0] d3a = '0, d3b = '0, d3c = '0;
  always @(posedge clk) begin
    if (b_ram_en && b_ram_we) mem3[b_ram_addr] <= b_ram_di;
    v3  <= {v3[1:0], b_ram_en && !b_ram_we};
    d3a <= mem3[b_ram_addr];
    d3b <= d3a;
    d3c <= d3b;
  end
  assign b_ram_do = v3[2] ? d3c : 32'h0BAD0BAD;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic          port;
    logic          wr;
    logic [DW-1:0] data;
  } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] shadow [1024];

  // Scoreboard: every ack must match the next expected completion.
  always @(negedge clk) begin
    if (!reset) begin
      exp_t          e;
      logic          gp;
      logic [DW-1:0] gd;
      n_cmp++;
      if (ram_we && !ram_en) begin
        n_fail++;
        $display("FAIL ram_we_without_en: ram_we=%0b ram_en=%0b required ram_we=0", ram_we, ram_en);
      end
      if (p0_do_ack || p1_do_ack) begin
        n_cmp++;
        gp = p1_do_ack;
        gd = p1_do_ack ? p1_do : p0_do;
        if (p0_do_ack && p1_do_ack) begin
          n_fail++;
          $display("FAIL dual_ack: p0_do_ack=1 p1_do_ack=1 required at most one");
        end else if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: port %0d acked, required no ack", gp);
        end else begin
          e = sb.pop_front();
          if (gp !== e.port) begin
            n_fail++;
            $display("FAIL ack_order: got port %0d, required port %0d", gp, e.port);
          end else if (!e.wr && gd !== e.data) begin
            n_fail++;
            $display("FAIL read_data: port %0d got %h, required %h", gp, gd, e.data);
          end
        end
      end
    end
  end

  task automatic req(input logic port, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input bit push);
    bit seen;
    seen = 0;
    @(negedge clk);
    if (push) begin
      if (w) sb.push_back({port, 1'b1, d});
      else   sb.push_back({port, 1'b0, shadow[a]});
    end
    if (w) shadow[a] = d;
    if (port) begin p1_en = 1; p1_we = w; p1_addr = a; p1_di = d; end
    else      begin p0_en = 1; p0_we = w; p0_addr = a; p0_di = d; end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = port ? p1_do_ack : p0_do_ack;
    end
    if (port) p1_en = 0; else p0_en = 0;
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL req_timeout: port %0d got no ack in 40 cycles, required an ack", port);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({ram_en, ram_we, busy, p0_do_ack, p1_do_ack} !== 5'b0 || ram_addr !== '0 ||
        ram_di !== '0 || p0_do !== '0 || p1_do !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%b we=%b busy=%b acks=%b%b addr=%h di=%h do0=%h do1=%h required all 0",
               ram_en, ram_we, busy, p0_do_ack, p1_do_ack, ram_addr, ram_di, p0_do, p1_do);
    end
    reset = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_readback();
    @(negedge clk);
    sb.push_back({1'b0, 1'b1, 32'h12345678});
    shadow[10'h3FF] = 32'h12345678;
    p0_en = 1; p0_we = 1; p0_addr = 10'h3FF; p0_di = 32'h12345678;
    @(negedge clk);
    n_cmp++;
    if (ram_en !== 1 || ram_we !== 1 || ram_addr !== 10'h3FF || ram_di !== 32'h12345678) begin
      n_fail++;
      $display("FAIL write_issue: en=%b we=%b addr=%h di=%h required 1 1 3ff 12345678",
               ram_en, ram_we, ram_addr, ram_di);
    end
    p0_addr = 10'h000; p0_di = 32'h0; p0_we = 0;
    @(negedge clk);
    n_cmp++;
    if (ram_en !== 0 || ram_we !== 0 || ram_addr !== 10'h3FF || ram_di !== 32'h12345678 ||
        p0_do_ack !== 1 || p0_do !== 32'h0) begin
      n_fail++;
      $display("FAIL write_ack: en=%b we=%b addr=%h di=%h ack=%b do=%h required 0 0 3ff 12345678 1 0",
               ram_en, ram_we, ram_addr, ram_di, p0_do_ack, p0_do);
    end
    p0_en = 0;
    req(1'b0, 1'b0, 10'h3FF, 32'h0, 1'b1);
  endtask

  task automatic test_single_read();
    req(1'b1, 1'b1, 10'd5, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    sb.push_back({1'b1, 1'b0, 32'hDEADBEEF});
    p1_en = 1; p1_we = 0; p1_addr = 10'd5;
    @(negedge clk);
    n_cmp++;
    if (ram_en !== 1 || ram_we !== 0 || ram_addr !== 10'd5) begin
      n_fail++;
      $display("FAIL read_issue: en=%b we=%b addr=%h required 1 0 005", ram_en, ram_we, ram_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (ram_en !== 0 || p1_do_ack !== 0) begin
      n_fail++;
      $display("FAIL read_wait: en=%b ack=%b required 0 0", ram_en, p1_do_ack);
    end
    @(negedge clk);
    n_cmp++;
    if (p1_do_ack !== 1 || p1_do !== 32'hDEADBEEF || p0_do_ack !== 0) begin
      n_fail++;
      $display("FAIL read_ack: ack1=%b do1=%h ack0=%b required 1 deadbeef 0", p1_do_ack, p1_do, p0_do_ack);
    end
    p1_en = 0;
    @(negedge clk);
    n_cmp++;
    if (p1_do_ack !== 0 || p1_do !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL read_ack_width: ack1=%b do1=%h required 0 deadbeef", p1_do_ack, p1_do);
    end
  endtask

  task automatic test_tie();
    sb.push_back({1'b0, 1'b1, 32'hA0A0A0A0});
    sb.push_back({1'b1, 1'b1, 32'hB1B1B1B1});
    fork
      req(1'b0, 1'b1, 10'h020, 32'hA0A0A0A0, 1'b0);
      req(1'b1, 1'b1, 10'h021, 32'hB1B1B1B1, 1'b0);
      begin
        bit done;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
          @(negedge clk);
          if (p0_do_ack) begin
            n_cmp++;
            if (busy !== 1) begin
              n_fail++;
              $display("FAIL tie_busy_p0: busy=%b required 1", busy);
            end
          end
          if (p1_do_ack) begin
            n_cmp++;
            if (busy !== 1) begin
              n_fail++;
              $display("FAIL tie_busy_p1: busy=%b required 1", busy);
            end
            @(negedge clk);
            n_cmp++;
            if (busy !== 0) begin
              n_fail++;
              $display("FAIL tie_busy_drop: busy=%b required 0", busy);
            end
            done = 1;
          end
        end
        n_cmp++;
        if (!done) begin
          n_fail++;
          $display("FAIL tie_timeout: p1 ack seen=0 required 1");
        end
      end
    join
  endtask

  task automatic test_fairness();
    sb.push_back({1'b0, 1'b1, 32'hF0000000});
    sb.push_back({1'b1, 1'b0, 32'hDEADBEEF});
    sb.push_back({1'b0, 1'b1, 32'hF0000001});
    sb.push_back({1'b0, 1'b1, 32'hF0000002});
    sb.push_back({1'b0, 1'b1, 32'hF0000003});
    fork
      for (int t = 0; t < 4; t++)
        req(1'b0, 1'b1, 10'(16 + t), 32'hF0000000 + t, 1'b0);
      begin
        @(negedge clk);
        req(1'b1, 1'b0, 10'd5, 32'h0, 1'b0);
      end
    join
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL fairness_pending: %0d completions missing, required 0", sb.size());
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    p1_en = 1; p1_we = 0; p1_addr = 10'd5;
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    n_cmp++;
    if ({ram_en, ram_we, busy, p0_do_ack, p1_do_ack} !== 5'b0 || p0_do !== '0 ||
        p1_do !== '0 || ram_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: en=%b we=%b busy=%b acks=%b%b do0=%h do1=%h addr=%h required all 0",
               ram_en, ram_we, busy, p0_do_ack, p1_do_ack, p0_do, p1_do, ram_addr);
    end
    p1_en = 0;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (p0_do_ack !== 0 || p1_do_ack !== 0) begin
        n_fail++;
        $display("FAIL abandoned_ack: acks=%b%b required 00", p0_do_ack, p1_do_ack);
      end
    end
    req(1'b1, 1'b0, 10'd5, 32'h0, 1'b1);
  endtask

  task automatic test_latency3();
    bit seen;
    seen = 0;
    @(negedge clk);
    b_en = 1; b_we = 1; b_addr = 10'd7; b_di = 32'hCAFEF00D;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = b_p0_ack;
    end
    b_en = 0;
    n_cmp++;
    if (!seen || b_p0_do !== 32'h0) begin
      n_fail++;
      $display("FAIL lat3_write: ack_seen=%b do=%h required 1 00000000", seen, b_p0_do);
    end
    @(negedge clk);
    b_en = 1; b_we = 0; b_addr = 10'd7;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (i == 1 && b_ram_en !== 1) begin
        n_fail++;
        $display("FAIL lat3_issue: ram_en=%b required 1", b_ram_en);
      end else if (i == 5 && (b_p0_ack !== 1 || b_p0_do !== 32'hCAFEF00D)) begin
        n_fail++;
        $display("FAIL lat3_ack: ack=%b do=%h required 1 cafef00d", b_p0_ack, b_p0_do);
      end else if (i != 1 && i != 5 && b_p0_ack !== 0) begin
        n_fail++;
        $display("FAIL lat3_ack_timing: cycle %0d ack=%b required 0", i, b_p0_ack);
      end
      if (i == 5) b_en = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_readback();
    test_single_read();
    test_tie();
    test_fairness();
    test_reset_in_wait();
    test_latency3();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
